// File: rtl/counter_chain_ctrl.sv
// counter_chain_ctrl: prescaled tick, start/stop/pause FSM and ripple-carry INC/CLR strobes for a
// chain of external 4-bit counter slices. Define COUNTER_CHAIN_SATURATE_EN to saturate at all-MAX.
module counter_chain_ctrl #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned TICK_DIV   = 100000,
  parameter int unsigned DIGIT_MAX  = 9
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  input  logic                    STOP,
  input  logic                    CLEAR,
  input  logic [4*NUM_DIGITS-1:0] Q_BUS,
  output logic [NUM_DIGITS-1:0]   INC,
  output logic [NUM_DIGITS-1:0]   CLR,
  output logic                    TICK,
  output logic                    RUNNING,
  output logic                    OVERFLOW
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PresLast = PW'(TICK_DIV - 1);
  localparam logic [3:0]    DigMax   = 4'(DIGIT_MAX);

`ifdef COUNTER_CHAIN_SATURATE_EN
  typedef enum logic [2:0] {StInit, StIdle, StRun, StPause, StSat} state_e;
`else
  typedef enum logic [2:0] {StInit, StIdle, StRun, StPause} state_e;
`endif

  state_e                state_q, state_d;
  logic [PW-1:0]         presc_q, presc_d;
  logic [NUM_DIGITS-1:0] inc_q, inc_d, clr_q, clr_d;
  logic                  tick_q, tick_d;
  logic                  ovf_q, ovf_d;

  logic [NUM_DIGITS:0]   carry;
  logic [NUM_DIGITS-1:0] dig_max, carry_inc, carry_clr;
  logic                  full;

  // Out-of-range digits compare unequal to MAX, so they get INC and stop the carry.
  always_comb begin
    carry    = '0;
    carry[0] = 1'b1;
    dig_max  = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      dig_max[i]   = (Q_BUS[4*i +: 4] == DigMax);
      carry[i+1]   = carry[i] & dig_max[i];
    end
  end

  assign carry_clr = carry[NUM_DIGITS-1:0] & dig_max;
  assign carry_inc = carry[NUM_DIGITS-1:0] & ~dig_max;
  assign full      = carry[NUM_DIGITS];

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    inc_d   = '0;
    clr_d   = '0;
    tick_d  = 1'b0;
    ovf_d   = ovf_q;
    if (state_q == StInit) begin
      clr_d   = '1;
      state_d = StIdle;
    end else if (CLEAR) begin
      clr_d   = '1;
      presc_d = '0;
      ovf_d   = 1'b0;
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle, StPause: begin
          if (!STOP && START) state_d = StRun;
        end
        StRun: begin
          if (STOP) begin
            state_d = StPause;
          end else if (presc_q == PresLast) begin
            presc_d = '0;
            tick_d  = 1'b1;
`ifdef COUNTER_CHAIN_SATURATE_EN
            if (full) begin
              ovf_d   = 1'b1;
              state_d = StSat;
            end else begin
              inc_d = carry_inc;
              clr_d = carry_clr;
            end
`else
            inc_d = carry_inc;
            clr_d = carry_clr;
            if (full) ovf_d = 1'b1;
`endif
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StInit;
      presc_q <= '0;
      inc_q   <= '0;
      clr_q   <= '0;
      tick_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      inc_q   <= inc_d;
      clr_q   <= clr_d;
      tick_q  <= tick_d;
      ovf_q   <= ovf_d;
    end
  end

  assign INC      = inc_q;
  assign CLR      = clr_q;
  assign TICK     = tick_q;
  assign RUNNING  = (state_q == StRun);
  assign OVERFLOW = ovf_q;

endmodule

// File: tb/tb_counter_chain_ctrl.sv
// Scoreboard bench for counter_chain_ctrl: 2 decimal digits, tick every 4 clocks, behavioural
// counter slices closing the Q_BUS loop. Expected strobe events carry the cycle they must appear in.
module tb_counter_chain_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       START = 1'b0;
  logic       STOP = 1'b0;
  logic       CLEAR = 1'b0;
  logic [7:0] Q_BUS;
  logic [1:0] INC;
  logic [1:0] CLR;
  logic       TICK;
  logic       RUNNING;
  logic       OVERFLOW;

  logic [7:0] q = 8'h73;
  logic       load_en = 1'b0;
  logic [7:0] load_val = 8'h00;
  int         cyc = 0;
  int         n_vec = 0;
  int         n_err = 0;

  typedef struct packed {
    logic [31:0] c;
    logic [1:0]  inc;
    logic [1:0]  clr;
    logic        tick;
    logic        run;
    logic        ovf;
  } ev_t;

  ev_t exp_q[$];
  ev_t got_ev;
  ev_t exp_ev;

  counter_chain_ctrl #(
    .NUM_DIGITS(2),
    .TICK_DIV  (4),
    .DIGIT_MAX (9)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .START   (START),
    .STOP    (STOP),
    .CLEAR   (CLEAR),
    .Q_BUS   (Q_BUS),
    .INC     (INC),
    .CLR     (CLR),
    .TICK    (TICK),
    .RUNNING (RUNNING),
    .OVERFLOW(OVERFLOW)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Behavioural 4-bit slices; load_en lets the bench preset the chain.
  assign Q_BUS = q;
  always @(posedge CLK) begin
    if (load_en) begin
      q <= load_val;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (CLR[i] && !INC[i]) q[4*i +: 4] <= 4'h0;
        else if (INC[i] && !CLR[i]) q[4*i +: 4] <= q[4*i +: 4] + 4'h1;
      end
    end
  end

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endfunction

  function automatic void push(input int c, input logic [1:0] i, input logic [1:0] cl,
                               input logic t, input logic r, input logic o);
    ev_t e;
    e.c    = c;
    e.inc  = i;
    e.clr  = cl;
    e.tick = t;
    e.run  = r;
    e.ovf  = o;
    exp_q.push_back(e);
  endfunction

  // Monitor: any strobe is an output event and must match the head of the scoreboard.
  always @(negedge CLK) begin
    if (!RST && (TICK || (|INC) || (|CLR))) begin
      got_ev.c    = cyc;
      got_ev.inc  = INC;
      got_ev.clr  = CLR;
      got_ev.tick = TICK;
      got_ev.run  = RUNNING;
      got_ev.ovf  = OVERFLOW;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_strobe: cyc=%0d inc=%b clr=%b tick=%b run=%b ovf=%b",
                 cyc, INC, CLR, TICK, RUNNING, OVERFLOW);
      end else begin
        exp_ev = exp_q.pop_front();
        if (got_ev !== exp_ev) begin
          n_err++;
          $display("FAIL strobe_event: got cyc=%0d inc=%b clr=%b tick=%b run=%b ovf=%b, expected cyc=%0d inc=%b clr=%b tick=%b run=%b ovf=%b",
                   got_ev.c, got_ev.inc, got_ev.clr, got_ev.tick, got_ev.run, got_ev.ovf,
                   exp_ev.c, exp_ev.inc, exp_ev.clr, exp_ev.tick, exp_ev.run, exp_ev.ovf);
        end
      end
    end
  end

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    #5000;
    $display("FAIL watchdog: bench did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1 RST = 1'b1;
    push(4, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0);
    goto(1);
    @(negedge CLK);
    chk("reset_outputs", {25'd0, INC, CLR, TICK, RUNNING, OVERFLOW}, 32'd0);
    goto(3);
    RST = 1'b0;

    goto(5);
    @(negedge CLK);
    chk("idle_running", RUNNING, 1'b0);
    chk("idle_inc", INC, 2'b00);

    // Count 00 -> 11: plain increments, then the 09 -> 10 carry.
    for (int k = 1; k <= 9; k++) push(7 + 4*k, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0);
    push(47, 2'b10, 2'b01, 1'b1, 1'b1, 1'b0);
    push(51, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0);
    goto(6);
    START = 1'b1;
    goto(7);
    START = 1'b0;
    goto(20);
    @(negedge CLK);
    chk("run_running", RUNNING, 1'b1);
    goto(49);
    @(negedge CLK);
    chk("q_after_carry", q, 8'h10);

    // STOP on terminal count suppresses the tick; resume fires on the first RUN cycle.
    push(61, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0);
    push(65, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0);
    goto(54);
    STOP = 1'b1;
    goto(55);
    STOP = 1'b0;
    goto(57);
    @(negedge CLK);
    chk("pause_running", RUNNING, 1'b0);
    goto(59);
    START = 1'b1;
    goto(60);
    START = 1'b0;

    // Preset 99 and hit the full-chain terminal.
    goto(66);
    load_en  = 1'b1;
    load_val = 8'h99;
    goto(67);
    load_en = 1'b0;
`ifdef COUNTER_CHAIN_SATURATE_EN
    push(69, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1);
`else
    push(69, 2'b00, 2'b11, 1'b1, 1'b1, 1'b1);
    push(73, 2'b01, 2'b00, 1'b1, 1'b1, 1'b1);
`endif
    goto(71);
    START = 1'b1;
    goto(72);
    START = 1'b0;
    goto(73);
    @(negedge CLK);
`ifdef COUNTER_CHAIN_SATURATE_EN
    chk("sat_running", RUNNING, 1'b0);
    chk("sat_q_held", q, 8'h99);
`else
    chk("wrap_running", RUNNING, 1'b1);
`endif
    chk("overflow_sticky", OVERFLOW, 1'b1);

    // CLEAR with STOP: CLEAR wins, prescaler restarts from 0.
    push(75, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0);
    push(82, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0);
    goto(74);
    CLEAR = 1'b1;
    STOP  = 1'b1;
    goto(75);
    CLEAR = 1'b0;
    STOP  = 1'b0;
    goto(76);
    @(negedge CLK);
    chk("q_cleared", q, 8'h00);
    goto(77);
    START = 1'b1;
    goto(78);
    START = 1'b0;

    // Reset in the cycle a tick is pending: nothing may come out, then INIT clears again.
    push(88, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0);
    goto(85);
    RST = 1'b1;
    @(negedge CLK);
    chk("rst_midrun_outputs", {25'd0, INC, CLR, TICK, RUNNING, OVERFLOW}, 32'd0);
    goto(87);
    RST = 1'b0;

    goto(92);
    @(negedge CLK);
    chk("events_outstanding", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/counter_chain_ctrl.md
Name: counter_chain_ctrl

Overview:
- Sequencer for a chain of NUM_DIGITS external 4-bit register-counters. Each counter slice has a per-slice CLK, CLR and INC, and feeds its Q back to this block.
- Generates a prescaled time tick, runs a start/stop/pause FSM, and issues per-digit INC/CLR pulses so the chain counts as a base-(DIGIT_MAX+1) number with ripple-carry wrap.
- Sits between the front-panel button pulses and the counter datapath; it is the only driver of the slice INC/CLR pins.

Parameters:
- NUM_DIGITS, 4, number of counter slices driven; legal range 1..8.
- TICK_DIV, 100000, CLK cycles per count tick; must be >= 2.
- DIGIT_MAX, 9, highest value a digit holds before wrapping to 0; legal range 1..15.

Ports:
- CLK, input, 1, system clock; all state updates on the rising edge.
- RST, input, 1, asynchronous active-high reset.
- START, input, 1, single-cycle pulse: begin or resume counting.
- STOP, input, 1, single-cycle pulse: pause counting.
- CLEAR, input, 1, single-cycle pulse: zero all digits and return to IDLE.
- Q_BUS, input, 4*NUM_DIGITS, current digit values; digit i is in Q_BUS[4i+3:4i], and digit 0 is least significant.
- INC, output, NUM_DIGITS, per-slice increment strobe.
- CLR, output, NUM_DIGITS, per-slice clear strobe.
- TICK, output, 1, one-cycle pulse aligned with each INC/CLR update.
- RUNNING, output, 1, high while in RUN.
- OVERFLOW, output, 1, sticky flag: the full chain wrapped or saturated.

Behaviour:
- Interface: one clock, CLK. Reset RST is asynchronous and active-high.
- Slice semantics, relied on by this block:
  - CLR=1, INC=0 clears the slice.
  - CLR=0, INC=1 increments the slice.
  - CLR=1, INC=1 holds the slice, so this block never asserts both on one digit.
- RST asserted: state=INIT, prescaler=0, and INC, CLR, TICK, RUNNING, OVERFLOW all 0.
- FSM states: INIT, IDLE, RUN, PAUSE, and SAT (SAT only exists when the optional feature is compiled in).
  - INIT: on the first edge after RST release, register CLR=all-ones for exactly one cycle, then go to IDLE. START, STOP and CLEAR are ignored in INIT.
  - IDLE: START -> RUN.
  - RUN: the prescaler counts 0..TICK_DIV-1 and wraps. STOP -> PAUSE; the prescaler holds its value.
  - PAUSE: START -> RUN; the prescaler resumes from its held value.
- Input priority when pulses coincide: CLEAR > STOP > START.
- CLEAR in IDLE, RUN, PAUSE or SAT: next cycle CLR=all-ones for one cycle, prescaler=0, OVERFLOW=0, state=IDLE.
- Tick condition: state=RUN, prescaler==TICK_DIV-1, and no STOP/CLEAR in the same cycle.
  - If STOP coincides with the terminal count, the tick is suppressed and the prescaler holds at TICK_DIV-1.
  - After a later START, the tick fires on the first RUN cycle.
- Carry rule, evaluated on Q_BUS in the tick cycle:
  - carry_0=1.
  - carry_i = carry_(i-1) AND (digit_(i-1)==DIGIT_MAX).
  - Digit i with carry_i=1 and value==DIGIT_MAX gets CLR_i.
  - Digit i with carry_i=1 and value<DIGIT_MAX gets INC_i.
  - All other digits get nothing.
- Output timing:
  - INC, CLR and TICK are registered: asserted the cycle after the tick condition, for exactly one cycle.
  - Latency from prescaler terminal count to slice update is 2 edges.
  - Q_BUS is stable when sampled because TICK_DIV >= 2.
- Full-chain terminal: every digit == DIGIT_MAX at a tick. Handling depends on the optional feature.
- Digit values greater than DIGIT_MAX on Q_BUS are treated as "not MAX": the digit is incremented (INC) and does not propagate carry.
- RST asserted mid-operation takes effect immediately, with no pending strobe completing.

Optional Feature:
- Macro: COUNTER_CHAIN_SATURATE_EN.
- Without the macro: at the full-chain terminal, all digits receive CLR (wrap to zero), OVERFLOW is set, and RUN continues.
- With the macro:
  - At the full-chain terminal, no INC/CLR is issued and TICK still pulses.
  - OVERFLOW is set, state -> SAT, RUNNING=0, and the digits hold at all-MAX.
  - In SAT, START and STOP are ignored; only CLEAR (or RST) leaves SAT.

Test Plan:
- Reset release, NUM_DIGITS=2, TICK_DIV=4, DIGIT_MAX=9 -> CLR=2'b11 for exactly one cycle on the first edge, then IDLE with RUNNING=0 and INC=0.
- START, then run 12 cycles -> TICK every 4 cycles, with INC=2'b01 each tick; the counter sequence is 00,01,02.
- Q_BUS=0x09 at a tick -> CLR=2'b01 and INC=2'b10 in the same cycle; the next Q_BUS is 0x10.
- STOP coinciding with the terminal count -> no TICK. START 5 cycles later -> TICK on the first RUN cycle, and the next tick 4 cycles after that.
- Q_BUS=0x99 at a tick:
  - Macro off: CLR=2'b11, OVERFLOW=1, RUNNING stays 1.
  - Macro on: INC=0 and CLR=0, OVERFLOW=1, RUNNING=0. A following START is ignored; CLEAR -> CLR=2'b11, OVERFLOW=0, state IDLE.
- CLEAR and STOP in the same cycle while in RUN -> CLR=all-ones, state IDLE, prescaler 0. RST pulsed mid-RUN -> all outputs 0 immediately, then the INIT clear sequence.
